bounce_gen: RTL and testbench

Switch-bounce emulator: takes a clean digital level and produces a contact-bounce waveform. Each edge on the input becomes a burst of pseudo-random toggles of bounded length, followed by a settle at the new level. It drives the `sw` input of the debouncer FSM in on-board loopback tests, so the debouncer can be exercised without a mechanical switch. A companion glitch counter reports the burst size for self-checking.

---
 rtl/bounce_gen_if.sv | 15 +
 rtl/bounce_gen.sv | 86 ++++++++
 tb/tb_bounce_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bounce_gen_if.sv
// bounce_gen_if: control and observation signals of the switch-bounce emulator.
//   en       1 = emulate bounce, 0 = passthrough
//   in       clean switch level
//   sw_out   bouncy level towards the debouncer
//   busy     burst in progress
//   glitches sw_out transitions in the current or last burst (saturating)
interface bounce_gen_if;
    logic       en;
    logic       in;
    logic       sw_out;
    logic       busy;
    logic [7:0] glitches;
    modport master (output en, in, input sw_out, busy, glitches);
    modport slave (input en, in, output sw_out, busy, glitches);
endinterface

// File: rtl/bounce_gen.sv
// bounce_gen: turns each edge of a clean level into a bounded pseudo-random toggle burst.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    bounce_gen_if slave: en, in in; sw_out, busy, glitches out
module bounce_gen #(
    parameter int          BOUNCE_CYCLES = 32,
    parameter int          MIN_HOLD      = 2,
    parameter int          HOLD_BITS     = 2,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input logic          clk,
    input logic          reset,
    bounce_gen_if.slave  bus
);
    typedef enum logic {IDLE, BOUNCE} state_t;
    state_t      state, n_state;
    logic        in_q, target, n_target, sw, n_sw;
    logic [15:0] window, n_window, lfsr;
    logic [31:0] hold, n_hold, reload;
    logic [7:0]  gl, n_gl, gl_inc;
    // hold counts down to zero, so a reload of MIN_HOLD+r-1 gives a run of MIN_HOLD+r cycles
    assign reload = 32'(MIN_HOLD) + 32'(lfsr[HOLD_BITS-1:0]) - 32'd1;
    assign gl_inc = (gl == 8'hFF) ? 8'hFF : gl + 8'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q   <= 1'b0;
            target <= 1'b0;
            sw     <= 1'b0;
            state  <= IDLE;
            window <= 16'd0;
            hold   <= 32'd0;
            gl     <= 8'd0;
            lfsr   <= SEED;
        end else begin
            in_q   <= bus.in;
            target <= n_target;
            sw     <= n_sw;
            state  <= n_state;
            window <= n_window;
            hold   <= n_hold;
            gl     <= n_gl;
            lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
    always_comb begin
        n_state  = state;
        n_target = target;
        n_sw     = sw;
        n_window = window;
        n_hold   = hold;
        n_gl     = gl;
        if (!bus.en) begin
            n_sw     = in_q;
            n_target = in_q;
            n_state  = IDLE;
        end else if (state == IDLE) begin
            if (in_q != target) begin
                n_target = in_q;
                n_sw     = in_q;
                n_window = 16'(BOUNCE_CYCLES - 1);
                n_hold   = reload;
                n_gl     = 8'd1;
                n_state  = BOUNCE;
            end
        end else if (in_q != target) begin
            // a new input edge restarts the window without leaving the burst
            n_target = in_q;
            n_sw     = in_q;
            n_window = 16'(BOUNCE_CYCLES - 1);
            n_hold   = reload;
            n_gl     = (sw != in_q) ? gl_inc : gl;
        end else if (window == 16'd0) begin
            n_sw    = target;
            n_state = IDLE;
            n_gl    = (sw != target) ? gl_inc : gl;
        end else begin
            n_window = window - 16'd1;
            n_sw     = (hold == 32'd0) ? !sw : sw;
            n_gl     = (hold == 32'd0) ? gl_inc : gl;
            n_hold   = (hold == 32'd0) ? reload : hold - 32'd1;
        end
    end
    assign bus.sw_out   = sw;
    assign bus.busy     = (state == BOUNCE);
    assign bus.glitches = gl;
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed checks of bounce_gen timing, bounce shape, passthrough, reset and saturation.
module tb_bounce_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   tr;
    logic prev_sw;
    logic [33:0] wa, we;
    bounce_gen_if bi ();
    bounce_gen_if si ();
    bounce_gen dut (.clk(clk), .reset(reset), .bus(bi));
    bounce_gen #(.BOUNCE_CYCLES(2000), .MIN_HOLD(1), .HOLD_BITS(1)) sat (.clk(clk), .reset(reset), .bus(si));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic stepc();
        step();
        if (bi.sw_out !== prev_sw) tr++;
        prev_sw = bi.sw_out;
    endtask
    // Reset with in=1 held, then the burst that follows release; the first
    // eleven sw_out values after release come from stepping the LFSR by hand.
    task automatic run_from_reset(output logic [33:0] w);
        logic [10:0] hv;
        int          n;
        logic        p;
        hv = 11'b01111100110;
        reset = 1'b1;
        bi.in = 1'b1;
        bi.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sw", bi.sw_out, 0);
            chk("rst_busy", bi.busy, 0);
            chk("rst_gl", bi.glitches, 0);
        end
        chk("rst_lfsr", dut.lfsr, 16'hACE1);
        reset = 1'b0;
        for (int i = 0; i < 34; i++) begin
            step();
            w[i] = bi.sw_out;
            if (i <= 10) chk("hand_sw", bi.sw_out, hv[i]);
            if (i == 0 || i == 33) chk("edge_busy0", bi.busy, 0);
            else chk("burst_busy", bi.busy, 1);
            if (i == 10) chk("hand_gl", bi.glitches, 4);
        end
        chk("settle_sw", bi.sw_out, 1);
        n = 0;
        p = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (w[i] !== p) n++;
            p = w[i];
        end
        chk("reset_burst_gl", bi.glitches, 64'(n));
    endtask
    // Full burst towards lvl from a settled !lvl: latency, busy window, run lengths, glitch count.
    task automatic burst_check(input logic lvl);
        int   run;
        logic p;
        bi.in = lvl;
        tr = 0;
        prev_sw = bi.sw_out;
        stepc();
        chk("bk_busy", bi.busy, 0);
        chk("bk_sw", bi.sw_out, !lvl);
        stepc();
        chk("b1_sw", bi.sw_out, lvl);
        chk("b1_busy", bi.busy, 1);
        run = 1;
        for (int i = 2; i <= 32; i++) begin
            p = bi.sw_out;
            stepc();
            chk("bw_busy", bi.busy, 1);
            if (bi.sw_out !== p) begin
                chk("run_len", (run >= 2 && run <= 5), 1);
                run = 1;
            end else run++;
        end
        stepc();
        chk("bs_busy", bi.busy, 0);
        chk("bs_sw", bi.sw_out, lvl);
        chk("bs_gl", bi.glitches, 64'(tr));
    endtask
    initial begin
        logic       prev;
        logic [7:0] g0;
        si.en = 1'b1;
        si.in = 1'b0;
        run_from_reset(wa);
        burst_check(1'b0);
        burst_check(1'b1);
        burst_check(1'b0);
        // retrigger: falling input edge 10 cycles into a rising burst
        bi.in = 1'b1;
        tr = 0;
        prev_sw = bi.sw_out;
        stepc();
        chk("rt_k_busy", bi.busy, 0);
        stepc();
        chk("rt_start_sw", bi.sw_out, 1);
        for (int i = 2; i <= 10; i++) begin
            stepc();
            chk("rt_busy_a", bi.busy, 1);
        end
        bi.in = 1'b0;
        stepc();
        chk("rt_busy_b", bi.busy, 1);
        stepc();
        chk("rt_j_sw", bi.sw_out, 0);
        chk("rt_j_busy", bi.busy, 1);
        for (int i = 1; i < 32; i++) begin
            stepc();
            chk("rt_busy_c", bi.busy, 1);
        end
        stepc();
        chk("rt_settle_busy", bi.busy, 0);
        chk("rt_settle_sw", bi.sw_out, 0);
        chk("rt_gl", bi.glitches, 64'(tr));
        // passthrough
        g0 = bi.glitches;
        bi.en = 1'b0;
        step();
        chk("pt0_sw", bi.sw_out, 0);
        prev = bi.in;
        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) bi.in = !bi.in;
            step();
            chk("pt_sw", bi.sw_out, prev);
            chk("pt_busy", bi.busy, 0);
            chk("pt_gl", bi.glitches, g0);
            prev = bi.in;
        end
        bi.in = 1'b0;
        step();
        step();
        bi.en = 1'b1;
        step();
        step();
        chk("reen_busy", bi.busy, 0);
        chk("reen_sw", bi.sw_out, 0);
        // reset five cycles into a burst, then an identical rerun
        bi.in = 1'b1;
        step();
        step();
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy", bi.busy, 1);
        run_from_reset(we);
        chk("repro", we, wa);
        // saturation of the glitch counter on a long burst
        si.in = 1'b1;
        step();
        step();
        chk("sat_start_busy", si.busy, 1);
        chk("sat_start_sw", si.sw_out, 1);
        for (int i = 2; i <= 2000; i++) begin
            step();
            if (i == 600) chk("sat_mid_gl", si.glitches, 255);
        end
        chk("sat_end_busy1", si.busy, 1);
        step();
        chk("sat_busy", si.busy, 0);
        chk("sat_sw", si.sw_out, 1);
        chk("sat_gl", si.glitches, 255);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
